// File: rtl/freq_scan_ctrl.sv
// Time-shared gated edge counter scanning NCH async inputs in index order.
// Define FREQ_SCAN_CONT_EN to chain scans when start is held through DONE.
module freq_scan_ctrl #(
  parameter int NCH           = 4,
  parameter int CW            = 12,
  parameter int GATE_CYCLES   = 50000000,
  parameter int SETTLE_CYCLES = 3,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           mclk,
  input  logic           rst,
  input  logic [NCH-1:0] sig,
  input  logic           start,
  input  logic [NCH-1:0] ch_mask,
  output logic           busy,
  output logic           done,
  output logic           result_valid,
  output logic [CW-1:0]  result,
  output logic [CHW-1:0] result_ch,
  output logic           result_sat
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_GATE   = 3'd2;
  localparam logic [2:0] S_STORE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [31:0] SET_LD  = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] GATE_LD = 32'(GATE_CYCLES - 1);

  logic [2:0]     state;
  logic [NCH-1:0] mask;
  logic [CHW-1:0] cur_ch;
  logic [31:0]    timer;
  logic           sync1, sync2, prev;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           sat, sat_nxt;
  logic           edge_det;
  logic [CHW:0]   first, nxt;

  // {found, index} of the lowest set bit of m at or above from
  function automatic logic [CHW:0] find_ch(
    input logic [NCH-1:0] m,
    input int             from
  );
    logic [CHW:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && i >= from) r = {1'b1, CHW'(i)};
    end
    return r;
  endfunction

  assign first    = find_ch(ch_mask, 0);
  assign nxt      = find_ch(mask, int'(cur_ch) + 1);
  assign edge_det = sync2 & ~prev;

  always_comb begin
    cnt_nxt = cnt;
    if (edge_det && cnt != CMAX) cnt_nxt = cnt + 1'b1;
    sat_nxt = sat | (cnt_nxt == CMAX);
  end

  assign done = (state == S_DONE);

`ifdef FREQ_SCAN_CONT_EN
  assign busy = (state == S_SETTLE) || (state == S_GATE) ||
                (state == S_STORE) ||
                (state == S_DONE && start && first[CHW]);
`else
  assign busy = (state == S_SETTLE) || (state == S_GATE) ||
                (state == S_STORE);
`endif

  always_ff @(posedge mclk) begin
    if (rst) begin
      state        <= S_IDLE;
      mask         <= '0;
      cur_ch       <= '0;
      timer        <= '0;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      prev         <= 1'b0;
      cnt          <= '0;
      sat          <= 1'b0;
      result       <= '0;
      result_ch    <= '0;
      result_sat   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      // prev tracks sync2 always, so the last SETTLE cycle primes it
      sync1        <= sig[cur_ch];
      sync2        <= sync1;
      prev         <= sync2;
      result_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mask <= ch_mask;
            if (first[CHW]) begin
              state  <= S_SETTLE;
              cur_ch <= first[CHW-1:0];
              timer  <= SET_LD;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_SETTLE: begin
          if (timer == '0) begin
            state <= S_GATE;
            timer <= GATE_LD;
            cnt   <= '0;
            sat   <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_GATE: begin
          cnt <= cnt_nxt;
          sat <= sat_nxt;
          if (timer == '0) begin
            state        <= S_STORE;
            result       <= cnt_nxt;
            result_sat   <= sat_nxt;
            result_ch    <= cur_ch;
            result_valid <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_STORE: begin
          if (nxt[CHW]) begin
            state  <= S_SETTLE;
            cur_ch <= nxt[CHW-1:0];
            timer  <= SET_LD;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
`ifdef FREQ_SCAN_CONT_EN
          if (start) begin
            mask <= ch_mask;
            if (first[CHW]) begin
              state  <= S_SETTLE;
              cur_ch <= first[CHW-1:0];
              timer  <= SET_LD;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            state <= S_IDLE;
          end
`else
          state <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
